// File: rtl/soc_mem_io_pkg.sv
// Shared definitions for the memory/IO slave: IO page word map, UART status
// bit position, UART frame shape and the transmitter state encoding.
// The CPU-side assembler helpers rely on these same constant values.
package soc_mem_io_pkg;

    // IO page word select: each register owns one bit of mem_addr[4:2]
    localparam int IO_LEDS_BIT      = 0;   // byte offset 0x04
    localparam int IO_UART_DATA_BIT = 1;   // byte offset 0x08
    localparam int IO_UART_CTRL_BIT = 2;   // byte offset 0x10

    // Position of the busy flag inside the UART_CTRL read word
    localparam int UART_BUSY_BIT    = 9;

    // 8N1 frame: start bit, eight data bits, stop bit
    localparam int UART_FRAME_BITS  = 10;

    typedef enum logic {
        UART_IDLE,
        UART_SEND
    } uart_state_t;

    // Exact mem_addr[4:2] pattern that selects the register owning bit_pos
    function automatic logic [2:0] io_word_code(input int bit_pos);
        return 3'(1 << bit_pos);
    endfunction

endpackage

// File: rtl/soc_mem_io_uart_tx.sv
// 8N1 UART transmitter, LSB first. A valid pulse while idle loads a full
// frame; a valid pulse while busy is dropped. txd idles high.
module uart_tx
    import soc_mem_io_pkg::*;
#(
    parameter int DIV = 10
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       valid,
    input  logic [7:0] data,
    output logic       busy,
    output logic       txd
);

    localparam int BW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [BW-1:0] BAUD_RELOAD = BW'(DIV - 1);
    localparam logic [3:0]    FRAME_LEN   = 4'(UART_FRAME_BITS);

    uart_state_t   state_q,   state_d;
    logic [9:0]    shifter_q, shifter_d;
    logic [3:0]    bitcnt_q,  bitcnt_d;
    logic [BW-1:0] baudcnt_q, baudcnt_d;

    // State register; synchronous reset parks the line high in IDLE
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every register samples pre-edge values.
        if (!resetn) begin
            state_q   <= UART_IDLE;
            shifter_q <= '1;
            bitcnt_q  <= '0;
            baudcnt_q <= '0;
        end else begin
            state_q   <= state_d;
            shifter_q <= shifter_d;
            bitcnt_q  <= bitcnt_d;
            baudcnt_q <= baudcnt_d;
        end
    end

    // Next-state: load a frame from IDLE, then shift one bit every DIV cycles
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        state_d   = state_q;
        shifter_d = shifter_q;
        bitcnt_d  = bitcnt_q;
        baudcnt_d = baudcnt_q;
        case (state_q)
            UART_IDLE: begin
                if (valid) begin
                    shifter_d = {1'b1, data, 1'b0};
                    bitcnt_d  = FRAME_LEN;
                    baudcnt_d = BAUD_RELOAD;
                    state_d   = UART_SEND;
                end
            end
            UART_SEND: begin
                if (baudcnt_q == '0) begin
                    // Fill with 1 so the line rests at the stop level afterwards
                    shifter_d = {1'b1, shifter_q[9:1]};
                    bitcnt_d  = bitcnt_q - 4'd1;
                    baudcnt_d = BAUD_RELOAD;
                    if (bitcnt_q == 4'd1) begin
                        state_d = UART_IDLE;
                    end
                end else begin
                    baudcnt_d = baudcnt_q - BW'(1);
                end
            end
            default: state_d = UART_IDLE;
        endcase
    end

    assign busy = (state_q == UART_SEND);
    assign txd  = shifter_q[0];

endmodule

// File: rtl/soc_mem_io.sv
// Memory-side slave of the processor bus: word RAM with byte-lane stores,
// plus an IO page holding the LED register and a UART transmitter.
// Every access completes in one cycle; read data is registered.
module soc_mem_io
    import soc_mem_io_pkg::*;
#(
    parameter int RAM_WORDS   = 256,
    parameter int IO_BIT      = 22,
    parameter int CLK_FREQ_HZ = 1_000_000,
    parameter int BAUD_RATE   = 115_200
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] mem_addr,
    input  logic        mem_rstrb,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wmask,
    output logic [31:0] mem_rdata,
    output logic [4:0]  leds,
    output logic        txd
);

    localparam int DIV   = CLK_FREQ_HZ / BAUD_RATE;
    localparam int IDX_W = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

    logic [31:0]      ram_q [RAM_WORDS];
    logic [IDX_W-1:0] ram_idx;
    logic             io_sel;
    logic             wr_en;
    logic [2:0]       io_word;
    logic             hit_leds;
    logic             hit_uart_data;
    logic             hit_uart_ctrl;
    logic             uart_valid;
    logic             uart_busy;
    logic [31:0]      io_rdata;
    logic [31:0]      rdata_q, rdata_d;
    logic [4:0]       leds_q,  leds_d;
    logic             unused_addr_lsbs;

    // Byte offset within the word never matters on this bus
    assign unused_addr_lsbs = ^mem_addr[1:0];

    // Address decode: word index wraps modulo the RAM depth
    assign ram_idx       = IDX_W'(mem_addr[31:2] % 30'(RAM_WORDS));
    assign io_sel        = mem_addr[IO_BIT];
    assign wr_en         = |mem_wmask;
    assign io_word       = mem_addr[4:2];
    assign hit_leds      = io_sel && (io_word == io_word_code(IO_LEDS_BIT));
    assign hit_uart_data = io_sel && (io_word == io_word_code(IO_UART_DATA_BIT));
    assign hit_uart_ctrl = io_sel && (io_word == io_word_code(IO_UART_CTRL_BIT));
    assign uart_valid    = wr_en && hit_uart_data;

    // RAM store: only the enabled byte lanes change
    always_ff @(posedge clk) begin
        // NOTE: the RAM is deliberately left out of reset so it maps onto block memory.
        if (wr_en && !io_sel) begin
            for (int lane = 0; lane < 4; lane++) begin
                if (mem_wmask[lane]) begin
                    ram_q[ram_idx][8*lane +: 8] <= mem_wdata[8*lane +: 8];
                end
            end
        end
    end

    // IO read mux: unmapped offsets and UART_DATA read as zero
    always_comb begin
        io_rdata = '0;
        if (hit_leds) begin
            io_rdata = {27'b0, leds_q};
        end else if (hit_uart_ctrl) begin
            io_rdata[UART_BUSY_BIT] = uart_busy;
        end
    end

    // Next read data and LED value; RAM read sees the pre-store word
    always_comb begin
        rdata_d = rdata_q;
        leds_d  = leds_q;
        if (mem_rstrb) begin
            rdata_d = io_sel ? io_rdata : ram_q[ram_idx];
        end
        if (wr_en && hit_leds) begin
            leds_d = mem_wdata[4:0];
        end
    end

    // Registered read data and LED register with synchronous reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rdata_q <= '0;
            leds_q  <= '0;
        end else begin
            rdata_q <= rdata_d;
            leds_q  <= leds_d;
        end
    end

    uart_tx #(
        .DIV (DIV)
    ) u_uart_tx (
        .clk    (clk),
        .resetn (resetn),
        .valid  (uart_valid),
        .data   (mem_wdata[7:0]),
        .busy   (uart_busy),
        .txd    (txd)
    );

    assign mem_rdata = rdata_q;
    assign leds      = leds_q;

endmodule

// File: tb/tb_soc_mem_io.sv
// Bench for soc_mem_io: RAM latency, byte masks, read-before-write, address
// wrap, LED/IO decode and UART framing including dropped writes and reset.
module tb_soc_mem_io;

    localparam logic [31:0] LEDS_ADDR = 32'h0040_0004;
    localparam logic [31:0] DATA_ADDR = 32'h0040_0008;
    localparam logic [31:0] GAP_ADDR  = 32'h0040_000C;
    localparam logic [31:0] CTRL_ADDR = 32'h0040_0010;
    localparam logic [31:0] BUSY_WORD = 32'h0000_0200;

    logic        clk;
    logic        resetn;
    logic [31:0] mem_addr;
    logic        mem_rstrb;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic [4:0]  leds;
    logic        txd;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_rd_q  [$];
    logic        exp_txd_q [$];

    soc_mem_io #(
        .RAM_WORDS   (256),
        .IO_BIT      (22),
        .CLK_FREQ_HZ (1_000_000),
        .BAUD_RATE   (100_000)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .mem_addr  (mem_addr),
        .mem_rstrb (mem_rstrb),
        .mem_wdata (mem_wdata),
        .mem_wmask (mem_wmask),
        .mem_rdata (mem_rdata),
        .leds      (leds),
        .txd       (txd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h expected=%08h @%0t", tag, got, exp, $time);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled there too
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic bus_idle();
        mem_rstrb = 1'b0;
        mem_wmask = 4'b0000;
        mem_wdata = 32'h0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask);
        mem_addr  = addr;
        mem_wdata = data;
        mem_wmask = mask;
        step();
        bus_idle();
    endtask

    // Read (optionally with a concurrent store); expectation queued at issue
    task automatic rdwr(input string tag, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] mask, input logic [31:0] exp);
        exp_rd_q.push_back(exp);
        mem_addr  = addr;
        mem_rstrb = 1'b1;
        mem_wdata = data;
        mem_wmask = mask;
        step();
        bus_idle();
        check(tag, mem_rdata, exp_rd_q.pop_front());
    endtask

    task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        rdwr(tag, addr, 32'h0, 4'b0000, exp);
    endtask

    // Send one byte and follow the line for the whole frame
    task automatic run_frame(input logic [7:0] data, input bit drop_mid, input bit reset_mid);
        logic [9:0] frame;
        frame = {1'b1, data, 1'b0};
        for (int k = 0; k < 10; k++) begin
            for (int r = 0; r < 10; r++) exp_txd_q.push_back(frame[k]);
        end
        wr(DATA_ADDR, {24'h0, data}, 4'b1111);
        for (int c = 0; c < 100; c++) begin
            check($sformatf("txd_c%0d", c), 32'(txd), 32'(exp_txd_q.pop_front()));
            if (c == 31) check("ctrl_busy_mid", mem_rdata, BUSY_WORD);
            if (c == 30 || c == 99) begin
                mem_addr  = CTRL_ADDR;
                mem_rstrb = 1'b1;
            end
            if (c == 20 && drop_mid) begin
                mem_addr  = DATA_ADDR;
                mem_wdata = 32'h0000_003C;
                mem_wmask = 4'b1111;
            end
            if (c == 35 && reset_mid) begin
                resetn = 1'b0;
                step();
                check("rst_txd", 32'(txd), 32'h1);
                check("rst_leds", 32'(leds), 32'h0);
                check("rst_rdata", mem_rdata, 32'h0);
                resetn = 1'b1;
                exp_txd_q.delete();
                rd("rst_ctrl", CTRL_ADDR, 32'h0);
                return;
            end
            step();
            bus_idle();
        end
        check("ctrl_busy_last", mem_rdata, BUSY_WORD);
        check("txd_after", 32'(txd), 32'h1);
        rd("ctrl_idle", CTRL_ADDR, 32'h0);
        for (int c = 0; c < 20; c++) begin
            check("txd_quiet", 32'(txd), 32'h1);
            step();
        end
    endtask

    initial begin
        resetn   = 1'b0;
        mem_addr = 32'h0;
        bus_idle();
        step();
        step();
        check("reset_rdata", mem_rdata, 32'h0);
        check("reset_leds", 32'(leds), 32'h0);
        check("reset_txd", 32'(txd), 32'h1);
        resetn = 1'b1;
        rd("reset_ctrl", CTRL_ADDR, 32'h0);

        // RAM latency and hold
        wr(32'h0000_000C, 32'hDEAD_BEEF, 4'b1111);
        rd("ram3", 32'h0000_000C, 32'hDEAD_BEEF);
        step();
        check("ram3_hold", mem_rdata, 32'hDEAD_BEEF);
        wr(32'h0000_000C, 32'h0, 4'b0000);
        rd("ram3_nomask", 32'h0000_000C, 32'hDEAD_BEEF);

        // Byte lanes and read-before-write
        wr(32'h0000_0014, 32'h1122_3344, 4'b1111);
        rdwr("ram5_rbw", 32'h0000_0014, 32'hAABB_CCDD, 4'b0101, 32'h1122_3344);
        rd("ram5_mask", 32'h0000_0014, 32'h11BB_33DD);
        rd("ram5_wrap", 32'h0000_0414, 32'h11BB_33DD);
        wr(32'h0000_0018, 32'hCAFE_F00D, 4'b1010);
        wr(32'h0000_0018, 32'h0000_0000, 4'b0101);
        rd("ram6_lanes", 32'h0000_0018, 32'hCA00_F000);

        // IO page decode
        wr(LEDS_ADDR, 32'h0000_001F, 4'b1111);
        check("leds_out", 32'(leds), 32'h1F);
        rd("leds_rd", LEDS_ADDR, 32'h0000_001F);
        rd("gap_rd", GAP_ADDR, 32'h0);
        rd("data_rd", DATA_ADDR, 32'h0);
        wr(32'h0040_0014, 32'hFFFF_FFFF, 4'b1111);
        rd("io_no_ram", 32'h0000_0014, 32'h11BB_33DD);
        rd("io_unmapped", 32'h0040_0014, 32'h0);
        wr(LEDS_ADDR, 32'h0000_0012, 4'b0000);
        check("leds_nomask", 32'(leds), 32'h1F);

        // UART frames
        run_frame(8'hA5, 1'b0, 1'b0);
        run_frame(8'h81, 1'b1, 1'b0);
        run_frame(8'hFF, 1'b0, 1'b1);
        run_frame(8'h5A, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
